// File: rtl/fm0_tx_encoder.sv
// Tag-side FM0 backscatter encoder: preamble, MSB-first data, dummy-1 terminator.
// Optional PILOT_TONE_EN adds 12 FM0 '0' pilot symbols ahead of the preamble.
module fm0_tx_encoder #(
  parameter int HALF_TARI = 16,
  parameter int MAX_BITS  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tx_start,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic [15:0]         tx_number,
  output logic                tx_out,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int IW = $clog2(MAX_BITS);
  localparam logic [11:0] H_LAST = 12'(HALF_TARI - 1);
  localparam logic [15:0] N_MAX = 16'(MAX_BITS);

  typedef enum logic [2:0] {
    IDLE,
`ifdef PILOT_TONE_EN
    PILOT,
`endif
    PREAMBLE,
    DATA,
    DUMMY,
    DONE
  } state_t;

  state_t              state;
  logic [11:0]         run_cnt;
  logic [1:0]          run_len;
  logic [2:0]          pre_idx;
  logic [15:0]         bit_cnt;
  logic                zero_half;
  logic [MAX_BITS-1:0] shreg;
`ifdef PILOT_TONE_EN
  logic [4:0]          pil_cnt;
`endif

  logic          h_end;
  logic          run_end;
  logic [IW-1:0] bit_idx;
  logic          next_bit;
  logic [15:0]   n_clamp;

  assign h_end    = (run_cnt == H_LAST);
  assign run_end  = h_end && (run_len == 2'd1);
  assign bit_idx  = IW'(bit_cnt - 16'd1);
  assign next_bit = shreg[bit_idx];
  assign n_clamp  = (tx_number > N_MAX) ? N_MAX : tx_number;

  function automatic logic [1:0] pre_len(input logic [2:0] i);
    unique case (i)
      3'd3:    pre_len = 2'd2;
      3'd5:    pre_len = 2'd3;
      3'd6:    pre_len = 2'd2;
      default: pre_len = 2'd1;
    endcase
  endfunction

  // Frame sequencer: run timing, level toggles and handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx_out    <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      run_cnt   <= '0;
      run_len   <= '0;
      pre_idx   <= '0;
      bit_cnt   <= '0;
      zero_half <= 1'b0;
      shreg     <= '0;
`ifdef PILOT_TONE_EN
      pil_cnt   <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE && state != DONE) begin
        run_cnt <= h_end ? 12'd0 : run_cnt + 12'd1;
        if (h_end && !run_end)
          run_len <= run_len - 2'd1;
      end
      unique case (state)
        IDLE: begin
          tx_out <= 1'b0;
          if (tx_start) begin
            shreg   <= tx_data;
            bit_cnt <= n_clamp;
            tx_out  <= 1'b1;
            tx_busy <= 1'b1;
            run_cnt <= '0;
            run_len <= 2'd1;
            pre_idx <= '0;
`ifdef PILOT_TONE_EN
            pil_cnt <= '0;
            state   <= PILOT;
`else
            state   <= PREAMBLE;
`endif
          end
        end
`ifdef PILOT_TONE_EN
        PILOT: begin
          if (run_end) begin
            run_len <= 2'd1;
            if (pil_cnt == 5'd23) begin
              tx_out <= 1'b1;
              state  <= PREAMBLE;
            end else begin
              pil_cnt <= pil_cnt + 5'd1;
              tx_out  <= ~tx_out;
            end
          end
        end
`endif
        PREAMBLE: begin
          if (run_end) begin
            tx_out <= ~tx_out;
            if (pre_idx != 3'd6) begin
              pre_idx <= pre_idx + 3'd1;
              run_len <= pre_len(pre_idx + 3'd1);
            end else if (bit_cnt != 16'd0) begin
              run_len   <= next_bit ? 2'd2 : 2'd1;
              zero_half <= ~next_bit;
              bit_cnt   <= bit_cnt - 16'd1;
              state     <= DATA;
            end else begin
              run_len <= 2'd2;
              state   <= DUMMY;
            end
          end
        end
        DATA: begin
          if (run_end) begin
            tx_out <= ~tx_out;
            if (zero_half) begin
              run_len   <= 2'd1;
              zero_half <= 1'b0;
            end else if (bit_cnt != 16'd0) begin
              run_len   <= next_bit ? 2'd2 : 2'd1;
              zero_half <= ~next_bit;
              bit_cnt   <= bit_cnt - 16'd1;
            end else begin
              run_len <= 2'd2;
              state   <= DUMMY;
            end
          end
        end
        DUMMY: begin
          if (run_end) begin
            tx_out  <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          tx_out <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          tx_out  <= 1'b0;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
